hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The module SHALL have the port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port `reset`, input, 1 bit: asynchronous, active-low (asserted at 0).
REQ-003 The module SHALL have the port `instr_d`, input, 32 bits: the instruction currently in D.
REQ-004 The module SHALL have the port `stall_pc`, output, 1 bit: 1 holds the PC.
REQ-005 The module SHALL have the port `stall_d`, output, 1 bit: 1 holds the F/D register.
REQ-006 The module SHALL have the port `flush_e`, output, 1 bit: 1 loads a bubble (all-zero instruction) into D/E.
REQ-007 The module SHALL have the port `fwd_rs_d`, output, 2 bits: D comparator/NPC rs source; 00 RF, 01 ALUOutM, 10 PC_M+4.
REQ-008 The module SHALL have the port `fwd_rt_d`, output, 2 bits: as `fwd_rs_d`, for rt.
REQ-009 The module SHALL have the port `fwd_rs_e`, output, 2 bits: E ALU rs source; 00 D/E latch, 01 ALUOutM, 10 W write data, 11 PC_M+4.
REQ-010 The module SHALL have the port `fwd_rt_e`, output, 2 bits: as `fwd_rs_e`, for rt.
REQ-011 The module SHALL have the port `md_busy`, output, 1 bit: 1 while the mult/div unit is computing.

Function
REQ-012 Each instruction SHALL be classified into rs-use, rt-use, Tuse (0 branch/jr, 1 ALU/store-address, 2 store-data), dest register (rd, rt, or 31 for jal/bgezal), Tnew-at-E (0 link, 1 ALU/mf*, 2 load) and md-class.
REQ-013 The unit SHALL keep descriptors {rs, rt, dest, tnew, src} for E, M and W in registers, shadowing the datapath pipeline registers.
REQ-014 Each cycle, M SHALL take E and W SHALL take M, with tnew decremented and saturating at 0.
REQ-015 When not stalled, E SHALL take the decoded D descriptor.
REQ-016 When stalled, E SHALL be loaded with a null descriptor (dest=0).
REQ-017 Stall SHALL be raised when rs-use and E.dest==rs!=0 and E.tnew>Tuse_rs; the same rule SHALL apply for rt and for the M stage.
REQ-018 Stall SHALL drive `stall_pc` = `stall_d` = `flush_e` = 1 in the same cycle, combinationally from the current state and `instr_d`.
REQ-019 `fwd_*_d` SHALL select M only when M.dest matches and is nonzero and M.tnew==0: 10 if M.src=link, else 01.
REQ-020 W-to-D forwarding SHALL NOT be selected, because the register file is write-through.
REQ-021 `fwd_*_e` priority SHALL be M over W.
REQ-022 For `fwd_*_e`, an M match SHALL yield 11 (link) or 01 (ALU).
REQ-023 For `fwd_*_e`, a W match SHALL yield 10.
REQ-024 Register 0 SHALL never match.
REQ-025 The mult/div counter SHALL be loaded when E holds mult/multu (5) or div/divu (10).
REQ-026 The mult/div counter SHALL decrement each cycle to 0, and `md_busy` SHALL equal (count!=0).
REQ-027 When D holds any md-class instruction (mult, div, mfhi, mflo, mthi, mtlo) and (md_busy or E is an md start), stall SHALL be raised.
REQ-028 A new md start SHALL reload the counter even if it is nonzero.
REQ-029 Simultaneous data-hazard and md stall SHALL be OR-ed; a single bubble SHALL be inserted per stalled cycle.
REQ-030 The all-zero instruction (sll $0) SHALL decode to no use, dest 0.

Reset
REQ-031 While `reset`=0, all descriptors SHALL be null and the mult/div counter SHALL be 0, immediately and independent of `clk`.
REQ-032 Under reset, outputs SHALL evaluate to `stall_*`=0, `flush_e`=0 (unless `instr_d` hazards a null pipe: never), `fwd_*`=00 and `md_busy`=0.
REQ-033 Reset mid-multiply SHALL abort the count; the first cycle after release SHALL show `md_busy`=0.

Structure
REQ-034 A shared package SHALL hold the opcode/funct constants, Tuse/Tnew constants, the src encodings (ALU, MEM, LINK), the forward-select codes, the descriptor typedef, and MD_MULT_CYC=5 and MD_DIV_CYC=10.
REQ-035 One sub-module, `hazard_decode`, SHALL map a 32-bit instruction to a descriptor plus use/Tuse/md flags; it SHALL be instantiated once, for D.

Verification
REQ-036 Scenario: lw $1,0($0) in E, then beq $1,$2 in D -> stall 2 cycles (E.tnew=2, then M.tnew=1), then `fwd_rs_d`=01 is not needed (W via RF) and beq proceeds on cycle 3.
REQ-037 Scenario: addu $3,$1,$2 in M with tnew 0, and beq $3,$0 in D -> no stall, `fwd_rs_d`=01.
REQ-038 Scenario: jal in M, and jr $31 in D -> `fwd_rs_d`=10, no stall; with jal in E -> no stall, forwarding occurs the next cycle.
REQ-039 Scenario: addu $4 in M and addu $4 in W, with E using $4 -> `fwd_rs_e`=01 (M wins); with dest $0 -> 00.
REQ-040 Scenario: div in E, then mflo in D -> stall for 11 cycles (1 E + 10 busy), `md_busy` high for exactly 10 cycles.
REQ-041 Scenario: `reset` pulled low during a multiply with count=3 -> `md_busy`=0 asynchronously, all `fwd_*`=00.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared constants and descriptor types for the
// hazard unit and its instruction classifier.
package hazard_unit_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  localparam logic [1:0] TUSE_BR  = 2'd0;
  localparam logic [1:0] TUSE_ALU = 2'd1;
  localparam logic [1:0] TUSE_ST  = 2'd2;

  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam logic [1:0] FWD_D_RF   = 2'b00;
  localparam logic [1:0] FWD_D_ALU  = 2'b01;
  localparam logic [1:0] FWD_D_LINK = 2'b10;

  localparam logic [1:0] FWD_E_REG  = 2'b00;
  localparam logic [1:0] FWD_E_ALU  = 2'b01;
  localparam logic [1:0] FWD_E_WB   = 2'b10;
  localparam logic [1:0] FWD_E_LINK = 2'b11;

  localparam logic [3:0] MD_MULT_CYC = 4'd5;
  localparam logic [3:0] MD_DIV_CYC  = 4'd10;

  typedef enum logic [1:0] {
    SRC_ALU,
    SRC_MEM,
    SRC_LINK
  } src_t;

  typedef enum logic [1:0] {
    MD_NONE,
    MD_MULT,
    MD_DIV
  } md_t;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic [1:0] tnew;
    src_t       src;
    md_t        md;
  } desc_t;

  function automatic desc_t desc_null();
    desc_t d;
    d.rs   = 5'd0;
    d.rt   = 5'd0;
    d.dest = 5'd0;
    d.tnew = 2'd0;
    d.src  = SRC_ALU;
    d.md   = MD_NONE;
    return d;
  endfunction

  // One stage older: result is one cycle closer.
  function automatic desc_t desc_age(desc_t d);
    desc_t a;
    a = d;
    if (a.tnew != 2'd0)
      a.tnew = a.tnew - 2'd1;
    return a;
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// Classifies one instruction into register use,
// Tuse, destination, Tnew and mult/div class.
module hazard_decode
  import hazard_unit_pkg::*;
(
  input  logic [31:0] instr,
  output desc_t       desc,
  output logic        use_rs,
  output logic        use_rt,
  output logic [1:0]  tuse_rs,
  output logic [1:0]  tuse_rt,
  output logic        md_class
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign fn = instr[5:0];

  logic special;
  logic f_shift, f_shiftv, f_alur;
  logic f_jr, f_jalr, f_mf, f_mt;
  logic f_mul, f_div, f_bz, f_bzal;
  logic f_jal, f_br2, f_br1;
  logic f_alui, f_lui, f_load, f_store;

  assign special = op == OP_SPECIAL;

  // The all-zero word is a pure bubble.
  assign f_shift = special && (instr != 32'd0)
    && (fn == FN_SLL || fn == FN_SRL
        || fn == FN_SRA);
  assign f_shiftv = special
    && (fn == FN_SLLV || fn == FN_SRLV
        || fn == FN_SRAV);
  assign f_alur = special
    && (fn == FN_ADD  || fn == FN_ADDU
        || fn == FN_SUB || fn == FN_SUBU
        || fn == FN_AND || fn == FN_OR
        || fn == FN_XOR || fn == FN_NOR
        || fn == FN_SLT || fn == FN_SLTU);
  assign f_jr   = special && fn == FN_JR;
  assign f_jalr = special && fn == FN_JALR;
  assign f_mf   = special
    && (fn == FN_MFHI || fn == FN_MFLO);
  assign f_mt   = special
    && (fn == FN_MTHI || fn == FN_MTLO);
  assign f_mul  = special
    && (fn == FN_MULT || fn == FN_MULTU);
  assign f_div  = special
    && (fn == FN_DIV || fn == FN_DIVU);

  assign f_bz = op == OP_REGIMM
    && (rt == RT_BLTZ || rt == RT_BGEZ);
  assign f_bzal = op == OP_REGIMM
    && (rt == RT_BLTZAL || rt == RT_BGEZAL);
  assign f_jal = op == OP_JAL;
  assign f_br2 = op == OP_BEQ || op == OP_BNE;
  assign f_br1 = op == OP_BLEZ || op == OP_BGTZ;
  assign f_alui = op == OP_ADDI || op == OP_ADDIU
    || op == OP_SLTI || op == OP_SLTIU
    || op == OP_ANDI || op == OP_ORI
    || op == OP_XORI;
  assign f_lui = op == OP_LUI;
  assign f_load = op == OP_LB || op == OP_LH
    || op == OP_LW || op == OP_LBU
    || op == OP_LHU;
  assign f_store = op == OP_SB || op == OP_SH
    || op == OP_SW;

  logic [4:0] dest;
  logic [1:0] tnew;
  src_t       src;
  md_t        md;

  always_comb begin
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    tuse_rs  = TUSE_ALU;
    tuse_rt  = TUSE_ALU;
    dest     = 5'd0;
    tnew     = TNEW_ALU;
    src      = SRC_ALU;
    md       = MD_NONE;
    md_class = 1'b0;
    unique case (1'b1)
      f_shift: begin
        use_rt = 1'b1;
        dest   = rd;
      end
      f_shiftv, f_alur: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        dest   = rd;
      end
      f_jr: begin
        use_rs  = 1'b1;
        tuse_rs = TUSE_BR;
      end
      f_jalr: begin
        use_rs  = 1'b1;
        tuse_rs = TUSE_BR;
        dest    = rd;
        tnew    = TNEW_LINK;
        src     = SRC_LINK;
      end
      f_mf: begin
        dest     = rd;
        md_class = 1'b1;
      end
      f_mt: begin
        use_rs   = 1'b1;
        md_class = 1'b1;
      end
      f_mul: begin
        use_rs   = 1'b1;
        use_rt   = 1'b1;
        md_class = 1'b1;
        md       = MD_MULT;
      end
      f_div: begin
        use_rs   = 1'b1;
        use_rt   = 1'b1;
        md_class = 1'b1;
        md       = MD_DIV;
      end
      f_bz: begin
        use_rs  = 1'b1;
        tuse_rs = TUSE_BR;
      end
      f_bzal: begin
        use_rs  = 1'b1;
        tuse_rs = TUSE_BR;
        dest    = 5'd31;
        tnew    = TNEW_LINK;
        src     = SRC_LINK;
      end
      f_jal: begin
        dest = 5'd31;
        tnew = TNEW_LINK;
        src  = SRC_LINK;
      end
      f_br2: begin
        use_rs  = 1'b1;
        use_rt  = 1'b1;
        tuse_rs = TUSE_BR;
        tuse_rt = TUSE_BR;
      end
      f_br1: begin
        use_rs  = 1'b1;
        tuse_rs = TUSE_BR;
      end
      f_alui: begin
        use_rs = 1'b1;
        dest   = rt;
      end
      f_lui: begin
        dest = rt;
      end
      f_load: begin
        use_rs = 1'b1;
        dest   = rt;
        tnew   = TNEW_LOAD;
        src    = SRC_MEM;
      end
      f_store: begin
        use_rs  = 1'b1;
        use_rt  = 1'b1;
        tuse_rt = TUSE_ST;
      end
      default: ;
    endcase
  end

  // Unused source fields read as $0 so they never match.
  always_comb begin
    desc.rs   = use_rs ? rs : 5'd0;
    desc.rt   = use_rt ? rt : 5'd0;
    desc.dest = dest;
    desc.tnew = tnew;
    desc.src  = src;
    desc.md   = md;
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush and bypass-select control with a
// mult/div busy tracker for a 5-stage pipeline.
module hazard_unit
  import hazard_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  output logic        stall_pc,
  output logic        stall_d,
  output logic        flush_e,
  output logic [1:0]  fwd_rs_d,
  output logic [1:0]  fwd_rt_d,
  output logic [1:0]  fwd_rs_e,
  output logic [1:0]  fwd_rt_e,
  output logic        md_busy
);

  desc_t      d_desc;
  logic       use_rs;
  logic       use_rt;
  logic [1:0] tuse_rs;
  logic [1:0] tuse_rt;
  logic       md_class;

  hazard_decode u_dec (
    .instr    (instr_d),
    .desc     (d_desc),
    .use_rs   (use_rs),
    .use_rt   (use_rt),
    .tuse_rs  (tuse_rs),
    .tuse_rt  (tuse_rt),
    .md_class (md_class)
  );

  desc_t      e_q;
  desc_t      m_q;
  desc_t      w_q;
  logic [3:0] md_cnt;

  function automatic logic data_hz(
    logic [4:0] r,
    logic [1:0] tuse,
    logic [4:0] e_dest,
    logic [1:0] e_tnew,
    logic [4:0] m_dest,
    logic [1:0] m_tnew
  );
    return (r != 5'd0)
      && ((e_dest == r && e_tnew > tuse)
          || (m_dest == r && m_tnew > tuse));
  endfunction

  function automatic logic [1:0] fsel_d(
    logic [4:0] r,
    logic [4:0] m_dest,
    logic [1:0] m_tnew,
    src_t       m_src
  );
    logic [1:0] sel;
    sel = FWD_D_RF;
    if (r != 5'd0 && m_dest == r
        && m_tnew == 2'd0)
      sel = (m_src == SRC_LINK) ? FWD_D_LINK
                                : FWD_D_ALU;
    return sel;
  endfunction

  // A not-yet-ready M producer shadows W.
  function automatic logic [1:0] fsel_e(
    logic [4:0] r,
    logic [4:0] m_dest,
    logic [1:0] m_tnew,
    src_t       m_src,
    logic [4:0] w_dest
  );
    logic [1:0] sel;
    sel = FWD_E_REG;
    if (r != 5'd0) begin
      if (m_dest == r) begin
        if (m_tnew == 2'd0)
          sel = (m_src == SRC_LINK) ? FWD_E_LINK
                                    : FWD_E_ALU;
      end else if (w_dest == r) begin
        sel = FWD_E_WB;
      end
    end
    return sel;
  endfunction

  logic hz_rs;
  logic hz_rt;
  logic md_stall;
  logic stall;

  assign md_busy = md_cnt != 4'd0;

  assign hz_rs = use_rs && data_hz(
    d_desc.rs, tuse_rs, e_q.dest, e_q.tnew,
    m_q.dest, m_q.tnew);
  assign hz_rt = use_rt && data_hz(
    d_desc.rt, tuse_rt, e_q.dest, e_q.tnew,
    m_q.dest, m_q.tnew);
  assign md_stall = md_class
    && (md_busy || e_q.md != MD_NONE);
  assign stall = hz_rs || hz_rt || md_stall;

  assign stall_pc = stall;
  assign stall_d  = stall;
  assign flush_e  = stall;

  assign fwd_rs_d = fsel_d(
    d_desc.rs, m_q.dest, m_q.tnew, m_q.src);
  assign fwd_rt_d = fsel_d(
    d_desc.rt, m_q.dest, m_q.tnew, m_q.src);
  assign fwd_rs_e = fsel_e(
    e_q.rs, m_q.dest, m_q.tnew, m_q.src,
    w_q.dest);
  assign fwd_rt_e = fsel_e(
    e_q.rt, m_q.dest, m_q.tnew, m_q.src,
    w_q.dest);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= desc_null();
      m_q <= desc_null();
      w_q <= desc_null();
    end else begin
      e_q <= stall ? desc_null() : d_desc;
      m_q <= desc_age(e_q);
      w_q <= desc_age(m_q);
    end
  end

  // A start in E restarts the count even mid-op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      md_cnt <= 4'd0;
    else if (e_q.md == MD_MULT)
      md_cnt <= MD_MULT_CYC;
    else if (e_q.md == MD_DIV)
      md_cnt <= MD_DIV_CYC;
    else if (md_cnt != 4'd0)
      md_cnt <= md_cnt - 4'd1;
  end

  logic unused_w;
  assign unused_w = ^{w_q.rs, w_q.rt, w_q.tnew,
                      w_q.src, w_q.md};

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench for hazard_unit: stimulus
// queues expected controls, a monitor pops and checks.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_d = 32'd0;
  logic        stall_pc;
  logic        stall_d;
  logic        flush_e;
  logic [1:0]  fwd_rs_d;
  logic [1:0]  fwd_rt_d;
  logic [1:0]  fwd_rs_e;
  logic [1:0]  fwd_rt_e;
  logic        md_busy;

  hazard_unit dut (
    .clk      (clk),
    .reset    (reset),
    .instr_d  (instr_d),
    .stall_pc (stall_pc),
    .stall_d  (stall_d),
    .flush_e  (flush_e),
    .fwd_rs_d (fwd_rs_d),
    .fwd_rt_d (fwd_rt_d),
    .fwd_rs_e (fwd_rs_e),
    .fwd_rt_e (fwd_rt_e),
    .md_busy  (md_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [11:0] act;

  assign act = {stall_pc, stall_d, flush_e,
                fwd_rs_d, fwd_rt_d,
                fwd_rs_e, fwd_rt_e, md_busy};

  // {stall x3, rs_d, rt_d, rs_e, rt_e, busy}
  function automatic logic [11:0] ev(
    input bit st, input logic [1:0] rsd,
    input logic [1:0] rtd, input logic [1:0] rse,
    input logic [1:0] rte, input bit busy);
    return {st, st, st, rsd, rtd, rse, rte, busy};
  endfunction

  function automatic logic [31:0] r_ins(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(
    input logic [5:0] op, input logic [4:0] rs,
    input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step(input logic [31:0] ins,
                      input logic [11:0] e,
                      input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    instr_d = ins;
    x.v = e;
    x.name = nm;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      cur = q.pop_front();
      n_chk++;
      if (act !== cur.v) begin
        n_fail++;
        $display("FAIL %s: got %b want %b",
                 cur.name, act, cur.v);
      end
    end
  end

  logic [11:0] z;
  logic [31:0] nop, lw1, beq12, addu3, beq30, jal;
  logic [31:0] jr31, addu4, addu5, addu6, addu0;
  logic [31:0] addu8, sw1, dv, mflo6, mult;
  logic [31:0] addu9, addu10, addu11;

  initial begin
    z      = ev(0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    nop    = 32'd0;
    lw1    = i_ins(6'h23, 5'd0, 5'd1, 16'd0);
    beq12  = i_ins(6'h04, 5'd1, 5'd2, 16'd4);
    addu3  = r_ins(5'd1, 5'd2, 5'd3, 6'h21);
    beq30  = i_ins(6'h04, 5'd3, 5'd0, 16'd4);
    jal    = {6'h03, 26'h40};
    jr31   = r_ins(5'd31, 5'd0, 5'd0, 6'h08);
    addu4  = r_ins(5'd1, 5'd2, 5'd4, 6'h21);
    addu5  = r_ins(5'd4, 5'd0, 5'd5, 6'h21);
    addu6  = r_ins(5'd0, 5'd0, 5'd6, 6'h21);
    addu0  = r_ins(5'd1, 5'd2, 5'd0, 6'h21);
    addu8  = r_ins(5'd0, 5'd0, 5'd8, 6'h21);
    sw1    = i_ins(6'h2b, 5'd0, 5'd1, 16'd0);
    dv     = r_ins(5'd1, 5'd2, 5'd0, 6'h1a);
    mflo6  = r_ins(5'd0, 5'd0, 5'd6, 6'h12);
    mult   = r_ins(5'd1, 5'd2, 5'd0, 6'h18);
    addu9  = r_ins(5'd1, 5'd2, 5'd9, 6'h21);
    addu10 = r_ins(5'd9, 5'd9, 5'd10, 6'h21);
    addu11 = r_ins(5'd9, 5'd10, 5'd11, 6'h21);

    #1 reset = 1'b0;
    step(nop, z, "rst_hold");
    @(negedge clk);
    #1 reset = 1'b1;
    step(nop, z, "idle0");
    step(nop, z, "idle1");

    // load-use on a branch: two bubbles
    step(lw1, z, "lw_d");
    step(beq12, ev(1, 0, 0, 0, 0, 0), "ld_use_e");
    step(beq12, ev(1, 0, 0, 0, 0, 0), "ld_use_m");
    step(beq12, z, "ld_use_go");
    repeat (3) step(nop, z, "a_drain");

    // store data is needed late: no stall
    step(lw1, z, "g_lw");
    step(nop, z, "g_gap");
    step(sw1, z, "st_tuse2");
    step(nop, ev(0, 0, 0, 0, 2'b10, 0), "st_fwd_w");
    repeat (2) step(nop, z, "g_drain");

    step(addu3, z, "addu3_d");
    step(nop, z, "b_gap");
    step(beq30, ev(0, 2'b01, 0, 0, 0, 0), "alu_fwd_d");
    step(nop, ev(0, 0, 0, 2'b10, 0, 0), "w_fwd_e");
    repeat (2) step(nop, z, "b_drain");

    step(jal, z, "jal_d");
    step(jr31, z, "jr_jal_e");
    step(jr31, ev(0, 2'b10, 0, 2'b11, 0, 0),
         "link_fwd");
    step(nop, ev(0, 0, 0, 2'b10, 0, 0), "link_w");
    repeat (2) step(nop, z, "c_drain");

    step(addu4, z, "addu4_a");
    step(addu4, z, "addu4_b");
    step(addu5, ev(0, 2'b01, 0, 0, 0, 0), "m_fwd_d");
    step(addu6, ev(0, 0, 0, 2'b01, 0, 0),
         "m_over_w");
    step(addu0, z, "addu0_d");
    step(addu8, z, "addu8_d");
    step(nop, z, "zero_dest");
    repeat (3) step(nop, z, "d_drain");

    // div then mflo: 1 + 10 stalled cycles
    step(dv, z, "div_d");
    step(mflo6, ev(1, 0, 0, 0, 0, 0), "md_e_start");
    repeat (10)
      step(mflo6, ev(1, 0, 0, 0, 0, 1),
           "md_busy_stall");
    step(mflo6, z, "md_done");
    repeat (3) step(nop, z, "e_drain");

    // reset during a multiply at count 3
    step(mult, z, "mult_d");
    step(addu9, z, "mult_e");
    step(addu10, ev(0, 0, 0, 0, 0, 1), "mult_busy");
    step(nop, ev(0, 0, 0, 2'b01, 2'b01, 1),
         "busy_fwd_e");
    step(addu11, z, "rst_mid");
    reset = 1'b0;
    step(nop, z, "rst_low");
    @(negedge clk);
    #1 reset = 1'b1;
    step(nop, z, "rst_release");
    step(nop, z, "f_drain");

    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d left want 0",
               q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
